// File: rtl/ttt_dot_render.sv
// Tic-tac-toe board renderer for a 10x14 row-strobed dot matrix.
// Board, win mask and turn are snapshotted per frame so a frame never tears.
module ttt_dot_render #(
    parameter int SCAN_DIV     = 2500,
    parameter int GUARD        = 250,
    parameter int BLINK_FRAMES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [17:0] board,
    input  logic        turn_o,
    input  logic [8:0]  win_mask,
    output logic [9:0]  dot_row,
    output logic [13:0] dot_col
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] GUARD_C   = DW'(GUARD);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [DW-1:0] div_q, div_d;
    logic [3:0]    row_q, row_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;
    logic [17:0]   snap_board_q, snap_board_d;
    logic [8:0]    snap_win_q, snap_win_d;
    logic          snap_turn_q, snap_turn_d;
    logic [9:0]    dot_row_q, dot_row_d;
    logic [13:0]   dot_col_q, dot_col_d;

    logic          div_wrap;
    logic          frame_end;
    logic [13:0]   pat;
    logic [3:0]    cr;
    logic [3:0]    gr;
    logic [1:0]    code;
    logic [2:0]    glyph;
    int            k;

    // Row pattern for the row currently being scanned, from snapshots only
    always_comb begin
        pat   = '0;
        cr    = '0;
        gr    = '0;
        code  = '0;
        glyph = '0;
        k     = 0;
        if (row_q == 4'd9) begin
            pat[10:8] = {3{snap_turn_q}};
            pat[2:0]  = {3{~snap_turn_q}};
        end else begin
            cr = (row_q >= 4'd6) ? 4'd2 : ((row_q >= 4'd3) ? 4'd1 : 4'd0);
            gr = row_q - (cr + cr + cr);
            pat[3] = 1'b1;
            pat[7] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                k    = 3 * int'(cr) + c;
                code = snap_board_q[2*k +: 2];
                if (snap_win_q[k] && !blink_q) begin
                    code = 2'd0;
                end
                case (code)
                    2'd1:    glyph = (gr == 4'd1) ? 3'b010 : 3'b101;
                    2'd2:    glyph = (gr == 4'd1) ? 3'b101 : 3'b111;
                    default: glyph = 3'b000;
                endcase
                pat[4*c +: 3] = glyph;
            end
        end
    end

    always_comb begin
        div_wrap     = (div_q == DIV_MAX);
        frame_end    = div_wrap && (row_q == 4'd9);
        div_d        = div_wrap ? '0 : div_q + 1'b1;
        row_d        = row_q;
        frame_d      = frame_q;
        blink_d      = blink_q;
        snap_board_d = snap_board_q;
        snap_win_d   = snap_win_q;
        snap_turn_d  = snap_turn_q;
        if (div_wrap) begin
            row_d = (row_q == 4'd9) ? 4'd0 : row_q + 4'd1;
        end
        if (frame_end) begin
            snap_board_d = board;
            snap_win_d   = win_mask;
            snap_turn_d  = turn_o;
            if (frame_q == FRAME_MAX) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        dot_row_d = en ? (10'd1 << row_q) : '0;
        dot_col_d = (en && (div_q >= GUARD_C)) ? pat : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            row_q        <= '0;
            frame_q      <= '0;
            blink_q      <= 1'b1;
            snap_board_q <= '0;
            snap_win_q   <= '0;
            snap_turn_q  <= 1'b0;
            dot_row_q    <= '0;
            dot_col_q    <= '0;
        end else begin
            div_q        <= div_d;
            row_q        <= row_d;
            frame_q      <= frame_d;
            blink_q      <= blink_d;
            snap_board_q <= snap_board_d;
            snap_win_q   <= snap_win_d;
            snap_turn_q  <= snap_turn_d;
            dot_row_q    <= dot_row_d;
            dot_col_q    <= dot_col_d;
        end
    end

    assign dot_row = dot_row_q;
    assign dot_col = dot_col_q;

endmodule

// File: tb/tb_ttt_dot_render.sv
// Scoreboard bench for ttt_dot_render: driver pushes expected outputs,
// monitor pops and compares after every clock edge.
module tb_ttt_dot_render;

    localparam int S = 4;
    localparam int G = 1;
    localparam int B = 2;
    localparam int FRAME = 10 * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [17:0] board = '0;
    logic        turn_o = 1'b0;
    logic [8:0]  win_mask = '0;
    logic [9:0]  dot_row;
    logic [13:0] dot_col;

    ttt_dot_render #(
        .SCAN_DIV(S),
        .GUARD(G),
        .BLINK_FRAMES(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .board(board),
        .turn_o(turn_o),
        .win_mask(win_mask),
        .dot_row(dot_row),
        .dot_col(dot_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [9:0]  row;
        logic [13:0] col;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    // Model state: clocks since reset release and the frame snapshot
    int          n_m = 0;
    logic [17:0] sb_m = '0;
    logic [8:0]  sw_m = '0;
    logic        st_m = 1'b0;

    // Pixel-wise image of one display row
    function automatic logic [13:0] pattern(int r, logic [17:0] b,
                                            logic [8:0] w, logic t,
                                            logic blink);
        logic [13:0] p;
        int k, px, gr, code;
        bit lit_x, lit_o;
        p = '0;
        if (r == 9) begin
            for (int x = 0; x < 3; x++) p[t ? 8 + x : x] = 1'b1;
            return p;
        end
        gr = r % 3;
        for (int bi = 0; bi < 11; bi++) begin
            px = bi % 4;
            if (px == 3) begin
                p[bi] = 1'b1;
            end else begin
                k = (r / 3) * 3 + bi / 4;
                code = int'((b >> (2 * k)) & 18'd3);
                if (w[k] && !blink) code = 0;
                lit_x = ((gr == 1) == (px == 1));
                lit_o = !(gr == 1 && px == 1);
                p[bi] = (code == 1 && lit_x) || (code == 2 && lit_o);
            end
        end
        return p;
    endfunction

    task automatic step(input logic r, input logic e, input logic [17:0] b,
                        input logic t, input logic [8:0] w);
        exp_t x;
        int dv, rw, f;
        logic blink;
        @(negedge clk);
        rst = r;
        en = e;
        board = b;
        turn_o = t;
        win_mask = w;
        x.n = n_m;
        if (r) begin
            x.row = '0;
            x.col = '0;
            n_m = 0;
            sb_m = '0;
            sw_m = '0;
            st_m = 1'b0;
        end else begin
            dv = n_m % S;
            rw = (n_m / S) % 10;
            f = n_m / FRAME;
            blink = ((f / B) % 2) == 0;
            x.row = e ? 10'(1 << rw) : 10'd0;
            x.col = (e && dv >= G) ? pattern(rw, sb_m, sw_m, st_m, blink)
                                   : 14'd0;
            if (n_m % FRAME == FRAME - 1) begin
                sb_m = b;
                sw_m = w;
                st_m = t;
            end
            n_m++;
        end
        sb_q.push_back(x);
    endtask

    task automatic run(input int cnt, input logic r, input logic e,
                       input logic [17:0] b, input logic t,
                       input logic [8:0] w);
        repeat (cnt) step(r, e, b, t, w);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #2;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            checks++;
            if (dot_row !== x.row) begin
                failures++;
                $display("FAIL dot_row n=%0d got=%h exp=%h", x.n, dot_row, x.row);
            end
            checks++;
            if (dot_col !== x.col) begin
                failures++;
                $display("FAIL dot_col n=%0d got=%h exp=%h", x.n, dot_col, x.col);
            end
            checks++;
            if ($countones(dot_row) > 1) begin
                failures++;
                $display("FAIL onehot n=%0d got=%h exp=<=1 bit", x.n, dot_row);
            end
        end
    end

    initial begin
        logic [17:0] rb;
        logic [8:0]  rw;
        logic        rt;
        // Reset, then code-3 board must render empty
        run(3, 1, 1, 18'h3FFFF, 0, 9'd0);
        run(2 * FRAME, 0, 1, 18'h3FFFF, 0, 9'd0);
        // X in cell 0, O in cell 4, O to move
        run(FRAME, 0, 1, 18'h00201, 1, 9'd0);
        run(FRAME / 2, 0, 1, 18'h00201, 1, 9'd0);
        run(FRAME / 2, 0, 1, 18'h00201, 0, 9'd0);
        run(FRAME, 0, 1, 18'h00201, 1, 9'd0);
        // Diagonal win blinking
        run(8 * FRAME, 0, 1, 18'h10101, 0, 9'b100010001);
        // Enable dropped mid-row
        run(6, 0, 1, 18'h10101, 0, 9'b100010001);
        run(5, 0, 0, 18'h10101, 0, 9'b100010001);
        run(29, 0, 1, 18'h10101, 0, 9'b100010001);
        // Reset in the middle of row 6
        run(26, 0, 1, 18'h00201, 1, 9'd0);
        run(2, 1, 1, 18'h00201, 1, 9'd0);
        run(2 * FRAME, 0, 1, 18'h00201, 1, 9'd0);
        // Randomized inputs with occasional blanking and reset
        rb = 18'($urandom);
        rw = 9'($urandom);
        rt = 1'($urandom);
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rb = 18'($urandom);
                rw = 9'($urandom);
                rt = 1'($urandom);
            end
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 15) != 0),
                 rb, rt, rw);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0 pending", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
